// File: rtl/umips_fetch_queue.sv
// Instruction-fetch front end: fetch-PC generator, in-order variable-latency imem port and prefetch queue.
// Optional macro UMIPS_FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module umips_fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc_plus_4
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [DATA_W-1:0] inst_mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] inst_mem_d [0:DEPTH-1];
    logic [ADDR_W-1:0] pcp4_mem_q [0:DEPTH-1];
    logic [ADDR_W-1:0] pcp4_mem_d [0:DEPTH-1];

    logic [CNT_W:0]    inflight;
    logic [ADDR_W-1:0] resp_pc_plus_4;
    logic [ADDR_W-1:0] target_pc;
    logic              xfer;
    logic              resp_drop;
    logic              resp_accept;
    logic              bypass_hit;
    logic              pop;
    logic              queue_pop;
    logic              push;

    always_comb begin
        inflight       = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req       = rst & ~redirect & (inflight < (CNT_W+1)'(DEPTH));
        imem_addr      = fetch_pc_q;
        xfer           = imem_req & imem_ready;
        resp_drop      = imem_rvalid & (drop_q != '0);
        resp_accept    = imem_rvalid & (drop_q == '0) & ~redirect;
        resp_pc_plus_4 = resp_pc_q + ADDR_W'(4);
        target_pc      = redirect_pc & ~ADDR_W'(3);

        inst       = inst_mem_q[rd_ptr_q];
        pc_plus_4  = pcp4_mem_q[rd_ptr_q];
        inst_valid = rst & (count_q != '0);
        bypass_hit = 1'b0;
`ifdef UMIPS_FETCH_BYPASS_EN
        bypass_hit = rst & resp_accept & (count_q == '0);
        if (bypass_hit) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            pc_plus_4  = resp_pc_plus_4;
        end
`endif
        pop       = inst_valid & inst_ready & ~redirect;
        queue_pop = pop & ~bypass_hit;
        // A forwarded response that decode takes never occupies a slot.
        push      = resp_accept & ~(bypass_hit & inst_ready);

        inst_mem_d = inst_mem_q;
        pcp4_mem_d = pcp4_mem_q;
        if (push) begin
            inst_mem_d[wr_ptr_q] = imem_rdata;
            pcp4_mem_d[wr_ptr_q] = resp_pc_plus_4;
        end

        fetch_pc_d    = xfer ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
        resp_pc_d     = resp_accept ? resp_pc_plus_4 : resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(xfer) - CNT_W'(imem_rvalid);
        drop_d        = drop_q - CNT_W'(resp_drop);
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);
        rd_ptr_d      = rd_ptr_q + PTR_W'(queue_pop);
        count_d       = count_q + CNT_W'(push) - CNT_W'(queue_pop);

        // Everything still in flight when the redirect lands is stale.
        if (redirect) begin
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            drop_d     = outstanding_d;
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            inst_mem_q    <= '{default: '0};
            pcp4_mem_q    <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            inst_mem_q    <= inst_mem_d;
            pcp4_mem_q    <= pcp4_mem_d;
        end
    end

endmodule

// File: tb/tb_umips_fetch_queue.sv
// Randomized bench for umips_fetch_queue: in-order memory model with variable latency and an
// epoch-tagged reference of the decode instruction stream.
module tb_umips_fetch_queue;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc_plus_4;

    umips_fetch_queue #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .pc_plus_4  (pc_plus_4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } req_t;

    req_t        memq[$];
    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    int          pops = 0;
    int          buffered = 0;
    int          epoch = 0;
    logic [31:0] exp_fetch;
    logic [31:0] exp_dec;

    int          ready_pct;
    int          iready_pct;
    int          redir_pct;
    int          lat_min;
    int          lat_max;
    logic        force_redir = 1'b0;
    logic [31:0] force_target = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic applyStimulus();
        rst         = 1'b1;
        redirect    = force_redir || ($urandom_range(99) < redir_pct);
        redirect_pc = force_redir ? force_target : (RESET_PC + ($urandom & 32'h0000_3FFF));
        imem_ready  = ($urandom_range(99) < ready_pct);
        inst_ready  = ($urandom_range(99) < iready_pct);
        if (memq.size() > 0 && memq[0].due <= cycle) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(memq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    // One clock: drive at the falling edge, check and advance the model, then cross the rising edge.
    task automatic stepCycle();
        logic exp_req;
        logic exp_valid;
        logic fresh;
        logic byp;
        @(negedge clk);
        applyStimulus();
        #1;
        fresh   = imem_rvalid && (memq[0].ep == epoch) && !redirect;
        exp_req = !redirect && ((buffered + memq.size()) < DEPTH);
`ifdef UMIPS_FETCH_BYPASS_EN
        byp = fresh && (buffered == 0);
`else
        byp = 1'b0;
`endif
        exp_valid = (buffered > 0) || byp;
        checkOutput("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
        checkOutput("inst_valid", {63'd0, inst_valid}, {63'd0, exp_valid});
        if (exp_req)
            checkOutput("imem_addr", {32'd0, imem_addr}, {32'd0, exp_fetch});
        if (exp_valid) begin
            checkOutput("inst", {32'd0, inst}, {32'd0, mem_data(exp_dec)});
            checkOutput("pc_plus_4", {32'd0, pc_plus_4}, {32'd0, exp_dec + 32'd4});
        end

        if (exp_req && imem_ready) begin
            memq.push_back('{addr: exp_fetch, due: cycle + $urandom_range(lat_max, lat_min), ep: epoch});
            exp_fetch += 32'd4;
        end
        if (imem_rvalid) begin
            void'(memq.pop_front());
            if (fresh) buffered++;
        end
        if (exp_valid && inst_ready && !redirect) begin
            buffered--;
            pops++;
            exp_dec += 32'd4;
        end
        if (redirect) begin
            buffered  = 0;
            epoch++;
            exp_fetch = {redirect_pc[31:2], 2'b00};
            exp_dec   = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        cycle++;
    endtask

    task automatic doReset(input int n);
        @(negedge clk);
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            checkOutput("rst_imem_req", {63'd0, imem_req}, 64'd0);
            checkOutput("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
            checkOutput("rst_imem_addr", {32'd0, imem_addr}, {32'd0, RESET_PC});
            checkOutput("rst_inst", {32'd0, inst}, 64'd0);
            checkOutput("rst_pc_plus_4", {32'd0, pc_plus_4}, 64'd0);
            @(posedge clk);
            cycle++;
        end
        memq.delete();
        buffered  = 0;
        exp_fetch = RESET_PC;
        exp_dec   = RESET_PC;
    endtask

    task automatic setKnobs(input int rp, input int ip, input int dp, input int lmin, input int lmax);
        ready_pct  = rp;
        iready_pct = ip;
        redir_pct  = dp;
        lat_min    = lmin;
        lat_max    = lmax;
    endtask

    task automatic forceRedirect(input logic [31:0] target);
        force_redir  = 1'b1;
        force_target = target;
        stepCycle();
        force_redir  = 1'b0;
    endtask

    initial begin
        int pops_before;
        doReset(3);

        // Steady stream with single-cycle memory: one instruction per cycle after fill.
        setKnobs(100, 100, 0, 1, 1);
        for (int i = 0; i < 10; i++) stepCycle();
        pops_before = pops;
        for (int i = 0; i < 20; i++) stepCycle();
        checkOutput("throughput", 64'(pops - pops_before), 64'd20);

        // Decode stalled long enough to fill the queue, then drained.
        setKnobs(100, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) stepCycle();
        setKnobs(100, 100, 0, 1, 1);
        for (int i = 0; i < 10; i++) stepCycle();

        // Three requests in flight at latency 3, then redirect.
        setKnobs(100, 100, 0, 3, 3);
        for (int i = 0; i < 3; i++) stepCycle();
        forceRedirect(32'h0000_0100);
        for (int i = 0; i < 10; i++) stepCycle();

        // Unaligned target.
        forceRedirect(32'h0000_0203);
        for (int i = 0; i < 8; i++) stepCycle();

        // Redirect coinciding with pops and responses.
        setKnobs(100, 100, 0, 1, 1);
        for (int i = 0; i < 4; i++) stepCycle();
        forceRedirect(32'h0000_0400);
        for (int i = 0; i < 6; i++) stepCycle();

        // Random traffic with a reset in the middle.
        setKnobs(75, 70, 5, 1, 3);
        for (int i = 0; i < 1500; i++) stepCycle();
        doReset(2);
        for (int i = 0; i < 1500; i++) stepCycle();

        checkOutput("pops_seen", {63'd0, (pops > 200)}, 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
